mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 3: number of requester ports, legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit, legal range 16..65535, used only when the configuration macro is defined.
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 m_rd_i  in  NPORT  per-port read request, level, held until that port's ack.
REQ-007 m_we_i  in  NPORT  per-port write request, level, held until that port's ack.
REQ-008 m_addr_i  in  NPORT*29  per-port address.
REQ-009 m_wdata_i  in  NPORT*256  per-port write data.
REQ-010 m_ack_o  out  NPORT  one-cycle completion pulse to the granted port.
REQ-011 m_err_o  out  1  valid with m_ack_o; 1 = aborted by timeout.
REQ-012 m_rdata_o  out  256  shared read data; valid in the ack cycle.
REQ-013 mem_addr_o  out  29  address to the memory controller.
REQ-014 mem_wdata_o  out  256  write data to the memory controller.
REQ-015 mem_rd_o  out  1  read strobe to the controller; the controller acts on its rising edge.
REQ-016 mem_we_o  out  1  write strobe to the controller; the controller acts on its rising edge.
REQ-017 mem_rdata_i  in  256  read data from the controller.
REQ-018 mem_ack_i  in  1  completion pulse from the controller, already in the clk domain.

Function
REQ-019 SHALL use the states IDLE, ISSUE, RESP and GAP.
REQ-020 IDLE: when any port has m_rd_i or m_we_i set, SHALL grant one port by round-robin, starting with the port after the last granted one.
REQ-021 IDLE grant: SHALL latch addr, wdata and op into mem_addr_o and mem_wdata_o, then go to ISSUE.
REQ-022 If a granted port has both m_rd_i and m_we_i set, SHALL perform the read; the write is served on a later grant.
REQ-023 ISSUE: SHALL hold exactly one of mem_rd_o or mem_we_o high, matching the op, until mem_ack_i is seen.
REQ-024 ISSUE on mem_ack_i: SHALL capture mem_rdata_i for reads, drop the strobe, and go to RESP.
REQ-025 RESP: SHALL pulse m_ack_o[grant] for exactly one cycle, with m_rdata_o valid for reads, then go to GAP.
REQ-026 GAP: SHALL hold both strobes low for one cycle so that the next strobe is a fresh rising edge, then go to IDLE.
REQ-027 A requester SHALL drop its request on the clock edge at which its m_ack_o is high; the arbiter does not sample requests in GAP.
REQ-028 mem_ack_i seen in IDLE, RESP or GAP SHALL be ignored.
REQ-029 Minimum turnaround SHALL be 4 cycles: grant, issue, ack, resp/gap; at most one transaction is outstanding.
REQ-030 Round-robin fairness: with all ports requesting continuously, each port SHALL be granted once per NPORT transactions.
REQ-031 Requests raised while another port is in service SHALL wait; none SHALL be lost.

Reset
REQ-032 Reset SHALL set state to IDLE, all strobes, acks and m_err_o to 0, latched address, data and rdata to 0, and the round-robin pointer so that port 0 has priority.
REQ-033 Reset mid-transaction SHALL drop the strobe immediately; no m_ack_o SHALL be issued for the aborted request.

Configuration
REQ-034 When MEM_ARBITER_TIMEOUT_EN is defined, a counter SHALL run in ISSUE; on reaching TIMEOUT_CYCLES without mem_ack_i, the arbiter SHALL drop the strobe and go to RESP with m_err_o=1 and m_rdata_o=0.
REQ-035 With MEM_ARBITER_TIMEOUT_EN defined, a late mem_ack_i after a timeout SHALL be ignored per REQ-028.
REQ-036 When MEM_ARBITER_TIMEOUT_EN is not defined, there SHALL be no counter, m_err_o SHALL be tied to 0, and ISSUE SHALL wait indefinitely.

Structure
REQ-037 Package mem_arbiter_pkg SHALL hold the state enum, ADDR_W=29, DATA_W=256 and the op encoding.
REQ-038 Sub-module rr_arbiter SHALL provide the round-robin grant: request vector and pointer in, one-hot grant out; purely combinational, with the pointer kept in the parent.

Verification
REQ-039 Port 1 reads addr 0x0000040 with mem_ack_i 5 cycles after mem_rd_o rises and mem_rdata_i=0xA5..A5 -> m_ack_o=3'b010 pulsed one cycle with m_rdata_o=0xA5..A5, and mem_rd_o low for at least one cycle afterward.
REQ-040 Ports 0, 1 and 2 all write continuously -> grant order 0,1,2,0,1,2, with mem_we_o showing 6 distinct rising edges.
REQ-041 Port 2 asserts both rd and we -> read served first, write served on a later grant.
REQ-042 MEM_ARBITER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no mem_ack_i -> ack with m_err_o=1 16 cycles after the strobe rises; a later stray mem_ack_i causes no output change.
REQ-043 rst_n asserted in ISSUE -> strobes 0 asynchronously, no ack issued; after release, port 0 is granted first when all ports request.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ------------------------------------------------------------------
// mem_arbiter_pkg: shared widths, FSM state and op encodings.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_arbiter_pkg;

  localparam int ADDR_W = 29;
  localparam int DATA_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter.sv
// ------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick, searching upward from i_ptr.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NPORT = 3,
  parameter int PTR_W = 2
) (
  input  logic [NPORT-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NPORT-1:0] o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NPORT; i++) begin
      // candidate = (ptr + i) mod NPORT, without a divider
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(NPORT)) begin
        w_sum = w_sum - (PTR_W+1)'(NPORT);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!o_valid && i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ------------------------------------------------------------------
// mem_arbiter: round-robin arbiter of NPORT requesters onto one memory controller.
// Optional ISSUE watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NPORT          = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORT-1:0]        m_rd_i,
  input  logic [NPORT-1:0]        m_we_i,
  input  logic [NPORT*ADDR_W-1:0] m_addr_i,
  input  logic [NPORT*DATA_W-1:0] m_wdata_i,
  output logic [NPORT-1:0]        m_ack_o,
  output logic                    m_err_o,
  output logic [DATA_W-1:0]       m_rdata_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  output logic                    mem_rd_o,
  output logic                    mem_we_o,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  input  logic                    mem_ack_i
);

  localparam int PTR_W = $clog2(NPORT);

  if (NPORT < 2 || NPORT > 8 || TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("mem_arbiter: NPORT or TIMEOUT_CYCLES out of range");
  end

  state_t           r_state;
  op_t              r_op;
  logic [PTR_W-1:0] r_ptr;
  logic [NPORT-1:0] r_grant;
  logic [NPORT-1:0] r_ack;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic             r_rd;
  logic             r_we;

  logic [NPORT-1:0]  w_req;
  logic [NPORT-1:0]  w_grant;
  logic [PTR_W-1:0]  w_idx;
  logic              w_valid;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [DATA_W-1:0] w_wdata_sel;
  logic              w_rd_sel;

  assign w_req = m_rd_i | m_we_i;

  rr_arbiter #(
    .NPORT (NPORT),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_comb begin
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (w_grant[p]) begin
        w_addr_sel  = m_addr_i[p*ADDR_W +: ADDR_W];
        w_wdata_sel = m_wdata_i[p*DATA_W +: DATA_W];
      end
    end
  end

  // A port holding both rd and we is served its read first.
  assign w_rd_sel = |(m_rd_i & w_grant);

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo_cnt;
  logic        r_err;
  assign m_err_o = r_err;
`else
  assign m_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_READ;
      r_ptr   <= '0;
      r_grant <= '0;
      r_ack   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rd    <= 1'b0;
      r_we    <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_grant <= w_grant;
            r_ptr   <= (w_idx == PTR_W'(NPORT - 1)) ? '0 : w_idx + PTR_W'(1);
            r_addr  <= w_addr_sel;
            r_wdata <= w_wdata_sel;
            r_op    <= w_rd_sel ? OP_READ : OP_WRITE;
            r_rd    <= w_rd_sel;
            r_we    <= !w_rd_sel;
            r_state <= ST_ISSUE;
`ifdef MEM_ARBITER_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          if (mem_ack_i) begin
            r_rd    <= 1'b0;
            r_we    <= 1'b0;
            r_ack   <= r_grant;
            if (r_op == OP_READ) begin
              r_rdata <= mem_rdata_i;
            end
            r_state <= ST_RESP;
          end
`ifdef MEM_ARBITER_TIMEOUT_EN
          else if (r_tmo_cnt == c_TMO_LAST) begin
            r_rd    <= 1'b0;
            r_we    <= 1'b0;
            r_ack   <= r_grant;
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
`endif
        end
        ST_RESP: begin
          r_ack   <= '0;
          r_state <= ST_GAP;
`ifdef MEM_ARBITER_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_ack_o     = r_ack;
  assign m_rdata_o   = r_rdata;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_rd_o    = r_rd;
  assign mem_we_o    = r_we;

endmodule

`default_nettype wire
